park_decrypt: RTL and testbench
===============================

Name: park_decrypt

Overview:
- Parking-lot exit decoder. A departing car presents a 3-bit encrypted token; the block decrypts it with the 3-bit lot pattern key and returns the parking-space number to free.
- Sits between the exit-gate token reader and the space-occupancy tracker.
- Output is registered. A one-hot release pulse drives the tracker directly.

Parameters:
- WIDTH, 3, bit width of token, pattern and park_number. All behaviour below is stated for 3.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- exit  input  1  decode request: a car is exiting and token is valid this cycle.
- token  input  3  encrypted token presented by the exiting car.
- pattern  input  3  decryption key (lot pattern). Sampled on the same edge as token.
- park_number  output  3  decrypted parking-space number (registered).
- valid  output  1  high for exactly one cycle after each accepted exit request.
- release  output  8  one-hot of park_number, asserted only while valid=1; otherwise all zero.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. No asynchronous paths; all outputs come from flops.
- Reset (rst=1 at a rising edge):
  - park_number <= 3'b000, valid <= 0, release <= 8'h00.
  - rst has priority over exit in the same cycle.
- Decrypt function: dec = token XOR pattern, bitwise, combinational. There are no invalid codes; all 8 values map to spaces 0..7.
- On a rising edge with rst=0 and exit=1:
  - park_number <= dec
  - valid <= 1
  - release <= (8'b1 << dec)
- On a rising edge with rst=0 and exit=0:
  - park_number holds its previous value.
  - valid <= 0, release <= 8'h00.
  - token and pattern are ignored, even if they change.
- Latency:
  - Exactly 1 cycle from the exit/token/pattern sample to the outputs.
  - Continuous exit=1 gives a new decode every cycle; valid stays high and park_number follows each sampled token^pattern.
- No handshake or backpressure. The consumer must take valid/release in the cycle they are asserted.
- Boundary cases:
  - token == pattern gives dec = 0: a legal space; valid=1, release=8'h01.
  - All-ones mismatch (token ^ pattern = 3'b111) gives release=8'h80.
  - rst asserted while valid=1: next edge clears all outputs. A pending exit in that cycle is dropped.
- X/Z on token or pattern while exit=0 must not disturb the outputs.

Test Plan:
- Reset: hold rst=1 two cycles with exit=1, token=3'b101, pattern=3'b111 -> park_number=0, valid=0, release=8'h00.
- Basic decode: rst=0, pattern=3'b111, token=3'b101, exit=1 for one cycle -> next cycle park_number=3'b010, valid=1, release=8'h04.
- Hold on idle: following that, pattern=3'b001, token=3'b001, exit=0 -> park_number stays 3'b010, valid=0, release=8'h00.
- Zero space: exit=1, token=3'b110, pattern=3'b110 -> park_number=0, valid=1, release=8'h01.
- Back-to-back: exit=1 for three cycles with (token,pattern) = (000,111), (011,001), (100,100) -> park_number = 7, 2, 0 on successive cycles; valid high for three cycles; release = 8'h80, 8'h04, 8'h01.
- Reset priority: rst=1 and exit=1 (token=3'b001, pattern=3'b000) in the same cycle -> park_number=0, valid=0, release=8'h00.

Source files
------------

// File: rtl/park_decrypt.sv
// Parking-lot exit decoder: XOR-decrypts the exiting car's token with the lot pattern
// and returns the registered space number, a one-cycle valid and a one-hot release.
module park_decrypt #(
  parameter int WIDTH = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_exit,
  input  logic [WIDTH-1:0]        i_token,
  input  logic [WIDTH-1:0]        i_pattern,
  output logic [WIDTH-1:0]        o_park_number,
  output logic                    o_valid,
  output logic [(2**WIDTH)-1:0]   o_release
);

  localparam int NSPACE = 2 ** WIDTH;

  logic [WIDTH-1:0]  w_dec;
  logic [NSPACE-1:0] w_onehot;
  logic [WIDTH-1:0]  r_park_number;
  logic              r_valid;
  logic [NSPACE-1:0] r_release;

  // Every code is a legal space, so the decode needs no range check.
  always_comb begin
    w_dec    = i_token ^ i_pattern;
    w_onehot = {{(NSPACE-1){1'b0}}, 1'b1} << w_dec;
  end

  // Reset wins over exit; idle cycles keep the last space but drop valid/release.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_park_number <= {WIDTH{1'b0}};
      r_valid       <= 1'b0;
      r_release     <= {NSPACE{1'b0}};
    end else if (i_exit) begin
      r_park_number <= w_dec;
      r_valid       <= 1'b1;
      r_release     <= w_onehot;
    end else begin
      r_park_number <= r_park_number;
      r_valid       <= 1'b0;
      r_release     <= {NSPACE{1'b0}};
    end
  end

  assign o_park_number = r_park_number;
  assign o_valid       = r_valid;
  assign o_release     = r_release;

endmodule

// File: tb/tb_park_decrypt.sv
// Directed self-checking bench for park_decrypt with hand-computed expectations.
module tb_park_decrypt;

  logic       clk;
  logic       rst;
  logic       exit_s;
  logic [2:0] token;
  logic [2:0] pattern;
  logic [2:0] park_number;
  logic       valid;
  logic [7:0] rel;

  int n_checks = 0;
  int n_errors = 0;

  park_decrypt #(.WIDTH(3)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_exit        (exit_s),
    .i_token       (token),
    .i_pattern     (pattern),
    .o_park_number (park_number),
    .o_valid       (valid),
    .o_release     (rel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] pn, input logic v, input logic [7:0] r);
    check_val({tag, ".park_number"}, {29'd0, park_number}, {29'd0, pn});
    check_val({tag, ".valid"},       {31'd0, valid},       {31'd0, v});
    check_val({tag, ".release"},     {24'd0, rel},         {24'd0, r});
  endtask

  // Apply inputs, take one rising edge, then settle 1 time unit before sampling.
  task automatic drive(input logic r, input logic e, input logic [2:0] t, input logic [2:0] p);
    rst = r; exit_s = e; token = t; pattern = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; exit_s = 1'b1; token = 3'b101; pattern = 3'b111;
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 3'b101, 3'b111);
    check_out("reset", 3'd0, 1'b0, 8'h00);

    drive(1'b0, 1'b1, 3'b101, 3'b111);
    check_out("basic", 3'b010, 1'b1, 8'h04);

    drive(1'b0, 1'b0, 3'b001, 3'b001);
    check_out("idle_hold", 3'b010, 1'b0, 8'h00);

    drive(1'b0, 1'b1, 3'b110, 3'b110);
    check_out("zero_space", 3'd0, 1'b1, 8'h01);

    drive(1'b0, 1'b1, 3'b000, 3'b111);
    check_out("b2b_0", 3'd7, 1'b1, 8'h80);
    drive(1'b0, 1'b1, 3'b011, 3'b001);
    check_out("b2b_1", 3'd2, 1'b1, 8'h04);
    drive(1'b0, 1'b1, 3'b100, 3'b100);
    check_out("b2b_2", 3'd0, 1'b1, 8'h01);

    drive(1'b1, 1'b1, 3'b001, 3'b000);
    check_out("rst_priority", 3'd0, 1'b0, 8'h00);

    drive(1'b0, 1'b1, 3'b011, 3'b000);
    check_out("decode3", 3'd3, 1'b1, 8'h08);
    drive(1'b0, 1'b0, 3'b111, 3'b000);
    check_out("idle_change_a", 3'd3, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 3'b010, 3'b101);
    check_out("idle_change_b", 3'd3, 1'b0, 8'h00);

    for (int d = 0; d < 8; d++) begin
      logic [2:0] dd;
      logic [7:0] oh;
      dd = 3'(d);
      oh = 8'h01 << d;
      drive(1'b0, 1'b1, dd ^ 3'b101, 3'b101);
      check_out($sformatf("sweep%0d", d), dd, 1'b1, oh);
    end

    drive(1'b0, 1'b0, 3'b000, 3'b000);
    check_out("final_idle", 3'd7, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
